// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types and constants for the two-digit 7-segment scan controller.
// Holds the scan FSM state encoding and the active-low anode patterns.
package seg_pkg;

  typedef enum logic [1:0] {
    UNITS_ON,
    BLANK_U,
    TENS_ON,
    BLANK_T
  } scan_state_t;

  localparam logic [1:0] AN_OFF   = 2'b11;
  localparam logic [1:0] AN_UNITS = 2'b10;
  localparam logic [1:0] AN_TENS  = 2'b01;
  localparam logic [3:0] TENS_MAX = 4'd9;

  function automatic logic [3:0] bcd_inc(
    input logic [3:0] v
  );
    return (v >= TENS_MAX) ? 4'd0 : v + 4'd1;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Display-side bundle: units digit and button in; decoder nibble,
// anodes, tens count and digit select out.
interface seg_scan_ctrl_if;

  logic [3:0] units_i;
  logic       btn_i;
  logic [3:0] bin_o;
  logic [1:0] an_o;
  logic [3:0] tens_o;
  logic       dig_sel_o;

  modport slave (
    input  units_i,
    input  btn_i,
    output bin_o,
    output an_o,
    output tens_o,
    output dig_sel_o
  );

  modport master (
    output units_i,
    output btn_i,
    input  bin_o,
    input  an_o,
    input  tens_o,
    input  dig_sel_o
  );

endinterface

// File: rtl/seg_scan_ctrl_btn_debounce.sv
// Button conditioner: 2-flop synchronizer, debounce counter, press pulse.
// Ports: clk, rst_n, btn_i (raw), btn_db_o (accepted level), press_o.
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 270000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic btn_db_o,
  output logic press_o
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  typedef logic [CW-1:0] dcnt_t;
  localparam dcnt_t LAST = dcnt_t'(DEBOUNCE_CYC - 1);

  logic  sync1_q;
  logic  sync2_q;
  dcnt_t cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive cycles of disagreement; any agreement restarts.
  // The pulse is registered, so the count lands one edge after the flip.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      btn_db_o <= 1'b0;
      press_o  <= 1'b0;
    end else begin
      press_o <= 1'b0;
      if (sync2_q != btn_db_o) begin
        if (cnt_q == LAST) begin
          cnt_q    <= '0;
          btn_db_o <= sync2_q;
          press_o  <= sync2_q;
        end else begin
          cnt_q <= cnt_q + dcnt_t'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Two-digit scan controller sharing one 7-seg decoder between units/tens.
// Ports: clk, rst_n, io (units_i, btn_i -> bin_o, an_o, tens_o, dig_sel_o).
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int REFRESH_CYC  = 27000,
  parameter int BLANK_CYC    = 270,
  parameter int DEBOUNCE_CYC = 270000,
  parameter bit LZ_BLANK     = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  seg_scan_ctrl_if.slave  io
);

  localparam int CMAX =
    (REFRESH_CYC > BLANK_CYC) ? REFRESH_CYC : BLANK_CYC;
  localparam int CW = $clog2(CMAX + 1);
  typedef logic [CW-1:0] scnt_t;
  localparam scnt_t ON_LAST = scnt_t'(REFRESH_CYC - 1);
  localparam scnt_t BL_LAST = scnt_t'(BLANK_CYC - 1);

  scan_state_t state_q;
  scan_state_t state_d;
  scnt_t       cnt_q;
  logic        slot_end;

  logic [3:0]  tens_q;
  logic        btn_db;
  logic        press;

  logic [1:0]  an_d;
  logic [3:0]  bin_d;
  logic        dig_d;
  logic [1:0]  an_q;
  logic [3:0]  bin_q;
  logic        dig_q;

  btn_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_btn (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_i    (io.btn_i),
    .btn_db_o (btn_db),
    .press_o  (press)
  );

  always_comb begin
    slot_end = 1'b0;
    unique case (1'b1)
      (state_q == UNITS_ON),
      (state_q == TENS_ON): slot_end = (cnt_q == ON_LAST);
      default:              slot_end = (cnt_q == BL_LAST);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BLANK_T;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= slot_end ? '0 : cnt_q + scnt_t'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    if (slot_end) begin
      unique case (state_q)
        BLANK_T:  state_d = UNITS_ON;
        UNITS_ON: state_d = BLANK_U;
        BLANK_U:  state_d = TENS_ON;
        TENS_ON:  state_d = BLANK_T;
        default:  state_d = BLANK_T;
      endcase
    end
  end

  // Blank states preload the upcoming digit so the decoder has settled
  // before its anode turns on.
  always_comb begin
    an_d  = AN_OFF;
    bin_d = io.units_i;
    dig_d = 1'b0;
    unique case (state_q)
      BLANK_T: begin
        an_d  = AN_OFF;
        bin_d = io.units_i;
        dig_d = 1'b0;
      end
      UNITS_ON: begin
        an_d  = AN_UNITS;
        bin_d = io.units_i;
        dig_d = 1'b0;
      end
      BLANK_U: begin
        an_d  = AN_OFF;
        bin_d = tens_q;
        dig_d = 1'b1;
      end
      TENS_ON: begin
        an_d  = (LZ_BLANK && tens_q == 4'd0) ? AN_OFF : AN_TENS;
        bin_d = tens_q;
        dig_d = 1'b1;
      end
      default: begin
        an_d  = AN_OFF;
        bin_d = io.units_i;
        dig_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q  <= AN_OFF;
      bin_q <= 4'h0;
      dig_q <= 1'b1;
    end else begin
      an_q  <= an_d;
      bin_q <= bin_d;
      dig_q <= dig_d;
    end
  end

  // Press only fires on a rising accepted level, so btn_db is high here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tens_q <= 4'd0;
    end else if (press && btn_db) begin
      tens_q <= bcd_inc(tens_q);
    end
  end

  assign io.an_o      = an_q;
  assign io.bin_o     = bin_q;
  assign io.dig_sel_o = dig_q;
  assign io.tens_o    = tens_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: directed and random button/units stimulus
// against a timeline model; runs LZ_BLANK=1 and LZ_BLANK=0 instances.
module tb_seg_scan_ctrl;

  localparam int R   = 8;
  localparam int B   = 2;
  localparam int DEB = 4;
  localparam int P   = 2 * (R + B);

  logic       clk;
  logic       rst_n;
  logic [3:0] units;
  logic       btn;

  int ncmp;
  int nerr;

  int k;
  int tens_m;
  bit acc;
  bit b1;
  bit b2;
  bit pend;
  int run;

  seg_scan_ctrl_if bus1 ();
  seg_scan_ctrl_if bus0 ();

  assign bus1.units_i = units;
  assign bus1.btn_i   = btn;
  assign bus0.units_i = units;
  assign bus0.btn_i   = btn;

  seg_scan_ctrl #(
    .REFRESH_CYC  (R),
    .BLANK_CYC    (B),
    .DEBOUNCE_CYC (DEB),
    .LZ_BLANK     (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus1)
  );

  seg_scan_ctrl #(
    .REFRESH_CYC  (R),
    .BLANK_CYC    (B),
    .DEBOUNCE_CYC (DEB),
    .LZ_BLANK     (1'b0)
  ) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    ncmp++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    k      = 0;
    tens_m = 0;
    acc    = 1'b0;
    b1     = 1'b0;
    b2     = 1'b0;
    pend   = 1'b0;
    run    = 0;
  endtask

  // One clock edge: advance the timeline model, then compare both DUTs.
  task automatic tick();
    int q;
    int t_old;
    logic [1:0] e_an1;
    logic [1:0] e_an0;
    logic [3:0] e_bin;
    logic       e_dig;
    @(posedge clk);
    k++;
    t_old = tens_m;
    if (pend) begin
      tens_m = (tens_m + 1) % 10;
      pend   = 1'b0;
    end
    if (b2 != acc) begin
      run++;
      if (run == DEB) begin
        acc = b2;
        run = 0;
        if (acc) pend = 1'b1;
      end
    end else begin
      run = 0;
    end
    b2 = b1;
    b1 = btn;
    q = (k - 1) % P;
    if (q < B) begin
      e_an1 = 2'b11; e_an0 = 2'b11;
      e_bin = units; e_dig = 1'b0;
    end else if (q < B + R) begin
      e_an1 = 2'b10; e_an0 = 2'b10;
      e_bin = units; e_dig = 1'b0;
    end else if (q < 2 * B + R) begin
      e_an1 = 2'b11; e_an0 = 2'b11;
      e_bin = 4'(t_old); e_dig = 1'b1;
    end else begin
      e_an1 = (t_old == 0) ? 2'b11 : 2'b01;
      e_an0 = 2'b01;
      e_bin = 4'(t_old); e_dig = 1'b1;
    end
    #1;
    chk("an", 8'(bus1.an_o), 8'(e_an1));
    chk("bin", 8'(bus1.bin_o), 8'(e_bin));
    chk("dig_sel", 8'(bus1.dig_sel_o), 8'(e_dig));
    chk("tens", 8'(bus1.tens_o), 8'(tens_m));
    chk("an_nolz", 8'(bus0.an_o), 8'(e_an0));
    chk("bin_nolz", 8'(bus0.bin_o), 8'(e_bin));
    chk("an_not00", 8'(bus1.an_o == 2'b00), 8'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_an", 8'(bus1.an_o), 8'h3);
    chk("rst_bin", 8'(bus1.bin_o), 8'h0);
    chk("rst_tens", 8'(bus1.tens_o), 8'h0);
    chk("rst_dig", 8'(bus1.dig_sel_o), 8'h1);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic press();
    btn = 1'b1;
    repeat (10) tick();
    btn = 1'b0;
    repeat (10) tick();
  endtask

  initial begin
    ncmp  = 0;
    nerr  = 0;
    rst_n = 1'b1;
    units = 4'h0;
    btn   = 1'b0;
    model_reset();
    #2;
    do_reset();

    units = 4'h5;
    repeat (2 * P) tick();

    repeat (3) press();
    repeat (P) tick();

    btn = 1'b1;
    repeat (3) tick();
    btn = 1'b0;
    repeat (10) tick();

    btn = 1'b1; tick();
    btn = 1'b0; tick();
    btn = 1'b1;
    repeat (10) tick();
    btn = 1'b0;
    repeat (10) tick();

    for (int i = 0; i < 40; i++) begin
      int hold;
      btn  = 1'($urandom_range(0, 1));
      hold = $urandom_range(1, 9);
      repeat (hold) begin
        units = 4'($urandom_range(0, 15));
        tick();
      end
    end
    btn = 1'b0;
    repeat (12) tick();

    for (int i = 0; i < 10 && tens_m != 9; i++) press();
    chk("pre_wrap", 8'(bus1.tens_o), 8'd9);
    press();
    repeat (P) tick();

    units = 4'h5;
    for (int i = 0; i < P && ((k % P) < B + 2 || (k % P) >= B + R); i++)
      tick();
    btn = 1'b1;
    repeat (3) tick();
    btn = 1'b0;
    do_reset();
    repeat (2 * P) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Two-digit scan controller for the common-anode 7-segment display. It time-multiplexes the single shared decodificador_siete instance between a units digit and a tens digit.
- The units digit comes from a 4-bit input. The tens digit is an internal BCD counter advanced by a debounced push-button.
- Drives the shared decoder's `bin` input and the two active-low anode enables, with a blanking gap between digits to suppress ghosting.

Parameters:
- REFRESH_CYC, 27000, clock cycles each digit is lit per slot (1 ms at 27 MHz)
- BLANK_CYC, 270, clock cycles with both anodes off between slots
- DEBOUNCE_CYC, 270000, cycles the synchronized button must hold a new level before it is accepted
- LZ_BLANK, 1, when 1 the tens digit stays dark while tens count == 0

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- units_i  in  4  units digit value, passed unmodified (0x0–0xF)
- btn_i  in  1  raw push-button, asynchronous, active-high
- bin_o  out  4  nibble to shared decodificador_siete `bin`
- an_o  out  2  anode enables, active-low; bit0 = units, bit1 = tens
- tens_o  out  4  current tens count (BCD 0–9)
- dig_sel_o  out  1  0 = units slot/blank, 1 = tens slot/blank

Behaviour:
- Reset (async assert, sync release via clk edge):
  - an_o=2'b11, bin_o=4'h0, tens_o=0, dig_sel_o=1
  - FSM=BLANK_T, slot counter=0, debouncer state=0
- FSM states: UNITS_ON, BLANK_U, TENS_ON, BLANK_T; cyclic order BLANK_T → UNITS_ON → BLANK_U → TENS_ON → BLANK_T.
  - ON states last exactly REFRESH_CYC cycles.
  - BLANK states last exactly BLANK_CYC cycles.
  - Frame period = 2·(REFRESH_CYC+BLANK_CYC).
- Slot counter runs 0..N-1 and clears on every state transition. BLANK_CYC=0 is not supported.
- All outputs are registered.
- UNITS_ON: an_o=2'b10, dig_sel_o=0, bin_o=units_i (sampled every cycle, one-cycle latency).
- TENS_ON: dig_sel_o=1, bin_o=tens count (one-cycle latency).
  - an_o=2'b01.
  - Exception: an_o=2'b11 when LZ_BLANK=1 and tens==0.
- BLANK_U / BLANK_T:
  - an_o=2'b11.
  - bin_o preloads the next slot's value: tens in BLANK_U, units in BLANK_T.
  - dig_sel_o reflects the next slot.
- At most one anode is low on any cycle, and never both.
- Button path:
  - 2-flop synchronizer feeds a debouncer.
  - When the synchronized level differs from the accepted level for DEBOUNCE_CYC consecutive cycles, the accepted level toggles.
  - Any mismatch gap restarts the count.
  - A rising edge of the accepted level gives a one-cycle inc pulse.
- Tens counter: on the inc pulse, 0→1→…→9→0 (wrap). Exactly one increment per accepted press; release and bounce produce none.
- Increment timing: tens_o updates on the (DEBOUNCE_CYC+3)th rising clk edge after btn_i rises, given btn_i is held stable.
- Increment during TENS_ON: the displayed bin_o follows on the next cycle; the slot timing is unaffected.
- Reset mid-operation: all state returns to reset values immediately. A press in progress is discarded.

Decomposition:
- Package seg_pkg:
  - state enum scan_state_t {UNITS_ON, BLANK_U, TENS_ON, BLANK_T}
  - constants AN_OFF=2'b11, AN_UNITS=2'b10, AN_TENS=2'b01, TENS_MAX=4'd9
- Sub-module btn_debounce (synchronizer + debounce counter + rising-edge pulse).
  - Parameter DEBOUNCE_CYC.
  - Ports clk, rst_n, btn_i, btn_db_o, press_o.
- The FSM, slot counter and tens counter stay in seg_scan_ctrl.

Test Plan (REFRESH_CYC=8, BLANK_CYC=2, DEBOUNCE_CYC=4, LZ_BLANK=1 unless stated):
- Reset: assert rst_n=0 during UNITS_ON → an_o=11, bin_o=0, tens_o=0 with no clk edge. After release, an_o=10 on the 3rd rising edge, with bin_o=units_i.
- Scan: units_i=5, tens=0, over 40 cycles → repeating pattern every 20 cycles: an_o=10/bin_o=5 ×8, 11 ×2, 11 ×8 (tens dark, leading-zero), 11 ×2. an_o never 00.
- Tens display: 3 accepted presses → tens_o=3. In the tens slot, an_o=01 and bin_o=3 for 8 cycles. With LZ_BLANK=0 and tens=0, an_o=01 and bin_o=0.
- Debounce: btn_i high 3 cycles then low → tens_o unchanged. btn_i toggling 1,0,1 every cycle, then high 10 cycles → exactly one increment, on the 7th edge after the final rise. Release → no change.
- Wrap: tens_o=9, one press → tens_o=0 and the tens digit blanks again.
- Passthrough/latency: units_i changes 5→4'hF mid UNITS_ON → bin_o=F on the next edge. During BLANK_T, bin_o already equals units_i while an_o=11.
